// File: rtl/md_unit_controller_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, URA group,
// FSM state type and op-classification helpers.
// Optional feature macro: MD_MADD_EN (enables madd/maddu/msub/msubu).
package md_unit_controller_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  localparam logic [1:0] URA_GRP_MD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Map any code this build does not implement onto MD_NOP.
  function automatic logic [3:0] md_norm_op(input logic [3:0] op);
    logic [3:0] r;
    r = MD_NOP;
    if (op <= MD_MTLO) r = op;
`ifdef MD_MADD_EN
    else if (op <= MD_MSUBU) r = op;
`endif
    return r;
  endfunction

  // True for ops that occupy the unit for a multi-cycle latency.
  function automatic logic md_is_arith(input logic [3:0] op);
    return (op != MD_NOP) && (op != MD_MTHI) && (op != MD_MTLO);
  endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational 64-bit {hi,lo} result for a normalised MD op.
// res_wr is low when HI/LO must be left untouched (divide by zero, non-arith ops).
// Optional feature macro: MD_MADD_EN (accumulate forms use acc as base).
module md_result_calc
  import md_unit_controller_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] acc,
  output logic [63:0] res,
  output logic        res_wr
);

  logic signed [31:0] a_s, dvs_s, quo_s, rem_s;
  logic signed [63:0] a_s64, b_s64, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        dvs_u, quo_u, rem_u;
  logic               div_ovf;

  // Products and quotients; divisors are forced to 1 where the real
  // division would be undefined so the operators never see 0 or -2^31/-1.
  always_comb begin
    a_s     = $signed(src_a);
    a_s64   = a_s;
    b_s64   = $signed(src_b);
    prod_s  = a_s64 * b_s64;
    prod_u  = {32'd0, src_a} * {32'd0, src_b};
    div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    dvs_u   = (src_b == 32'd0) ? 32'd1 : src_b;
    dvs_s   = (src_b == 32'd0 || div_ovf) ? 32'sd1 : $signed(src_b);
    quo_s   = div_ovf ? 32'sh8000_0000 : (a_s / dvs_s);
    rem_s   = div_ovf ? 32'sd0 : (a_s % dvs_s);
    quo_u   = src_a / dvs_u;
    rem_u   = src_a % dvs_u;
  end

  // Select the result for the op.
  always_comb begin
    res    = acc;
    res_wr = 1'b0;
    case (op)
      MD_MULT:  begin res = prod_s; res_wr = 1'b1; end
      MD_MULTU: begin res = prod_u; res_wr = 1'b1; end
      MD_DIV:   begin res = {rem_s, quo_s}; res_wr = (src_b != 32'd0); end
      MD_DIVU:  begin res = {rem_u, quo_u}; res_wr = (src_b != 32'd0); end
`ifdef MD_MADD_EN
      MD_MADD:  begin res = acc + prod_s; res_wr = 1'b1; end
      MD_MADDU: begin res = acc + prod_u; res_wr = 1'b1; end
      MD_MSUB:  begin res = acc - prod_s; res_wr = 1'b1; end
      MD_MSUBU: begin res = acc - prod_u; res_wr = 1'b1; end
`endif
      default:  begin res = acc; res_wr = 1'b0; end
    endcase
  end

`ifndef MD_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc;
`endif

endmodule

// File: rtl/md_unit_controller.sv
// Multiply/divide unit sequencer: owns HI/LO, models multi-cycle latency
// with a countdown, and stalls D/E while the unit is busy.
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu).
module md_unit_controller
  import md_unit_controller_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        rd_en,
  input  logic [6:0]  rd_ura,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       op_n;
  logic             arith, is_div, md_rd, accept;
  logic             load_res, commit;
  logic [63:0]      calc_res;
  logic             calc_wr;
  logic [31:0]      res_hi, res_lo;
  logic             res_wr;

  assign op_n    = md_norm_op(op);
  assign arith   = md_is_arith(op_n);
  assign is_div  = (op_n == MD_DIV) || (op_n == MD_DIVU);
  assign busy    = (cnt != '0);
  assign md_rd   = rd_en && (rd_ura[6:5] == URA_GRP_MD);
  assign accept  = op_valid && !flush && !busy && (op_n != MD_NOP);
  // The reader is held off while a result is in flight, including the
  // accept cycle itself, since HI/LO are not yet updated.
  assign stall   = (busy && op_valid && (op_n != MD_NOP)) ||
                   ((busy || (accept && arith)) && md_rd);
  assign rd_data = rd_ura[0] ? lo : hi;

  logic unused_ura;
  assign unused_ura = ^rd_ura[4:1];

  md_result_calc u_calc (
    .op     (op_n),
    .src_a  (src_a),
    .src_b  (src_b),
    .acc    ({hi, lo}),
    .res    (calc_res),
    .res_wr (calc_wr)
  );

  // Next-state, countdown and load/commit strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_res  = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && arith) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
          load_res  = 1'b1;
        end
      end
      ST_BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and countdown register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pending result capture and architectural HI/LO update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (load_res) begin
        res_hi <= calc_res[63:32];
        res_lo <= calc_res[31:0];
        res_wr <= calc_wr;
      end
      if (commit && res_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (accept && (op_n == MD_MTHI)) begin
        hi <= src_a;
      end else if (accept && (op_n == MD_MTLO)) begin
        lo <= src_a;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_controller.sv
// Self-checking bench for md_unit_controller (scoreboard of expected {hi,lo}).
module tb_md_unit_controller;
  import md_unit_controller_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        rd_en = 1'b0;
  logic [6:0]  rd_ura = 7'd0;
  logic        stall, busy;
  logic [31:0] rd_data, hi, lo;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb_q[$];
  logic [63:0] m_hl = 64'd0;

  always #5 clk = ~clk;

  md_unit_controller #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .rd_en(rd_en),
    .rd_ura(rd_ura), .stall(stall), .busy(busy), .rd_data(rd_data),
    .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour; division worked through magnitudes and sign fix-up.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    logic signed [63:0] ps;
    logic [63:0] pu;
    logic [31:0] ma, mb, q, r;
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu = {32'd0, a} * {32'd0, b};
    case (o)
      MD_MULT:  return ps;
      MD_MULTU: return pu;
      MD_DIV: begin
        if (b == 32'd0) return hl;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q = ma / mb;
        r = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      MD_DIVU:  return (b == 32'd0) ? hl : {a % b, a / b};
      MD_MTHI:  return {a, hl[31:0]};
      MD_MTLO:  return {hl[63:32], a};
`ifdef MD_MADD_EN
      MD_MADD:  return hl + ps;
      MD_MADDU: return hl + pu;
      MD_MSUB:  return hl - ps;
      MD_MSUBU: return hl - pu;
`endif
      default:  return hl;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
    op = MD_NOP;
    flush = 1'b0;
  endtask

  // Counts cycles busy stays high (bounded); ends on the negedge after commit.
  task automatic wait_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check(tag, {hi, lo}, e);
      m_hl = e;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat);
    int n;
    sb_q.push_back(model(o, a, b, m_hl));
    present(o, a, b);
    tick();
    idle_in();
    wait_busy(n);
    check({tag, "_lat"}, n, lat);
    pop_check(tag);
  endtask

  initial begin
    int n;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    tick();
    reset_n = 1'b1;

    // mult -3 * 7
    run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    rd_en = 1'b1;
    rd_ura = 7'b1000000;
    #1;
    check("idle_stall", stall, 1'b0);
    check("idle_rd_hi", rd_data, 32'hFFFF_FFFF);
    rd_en = 1'b0;

    // div -7 / 2 with mflo waiting in D
    tick();
    sb_q.push_back(model(MD_DIV, 32'hFFFF_FFF9, 32'd2, m_hl));
    present(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    rd_en = 1'b1;
    rd_ura = 7'b1000001;
    @(negedge clk);
    check("div_accept_stall", stall, 1'b1);
    tick();
    idle_in();
    wait_stall(n);
    check("div_stall_cycles", n, 10);
    check("div_rd_lo", rd_data, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    pop_check("div");
    rd_en = 1'b0;

    // divide by zero after mthi
    run_op("mthi", MD_MTHI, 32'h0000_1234, 32'd0, 0);
    run_op("divu0", MD_DIVU, 32'h55, 32'd0, 10);
    check("divu0_hi", hi, 32'h0000_1234);

    // flushed mult is dropped
    present(MD_MULT, 32'd5, 32'd6);
    flush = 1'b1;
    tick();
    idle_in();
    @(negedge clk);
    check("flush_busy", busy, 1'b0);
    check("flush_hilo", {hi, lo}, m_hl);

    // flush during a div does not abort it; other URA groups do not stall
    sb_q.push_back(model(MD_DIV, 32'd100, 32'd7, m_hl));
    present(MD_DIV, 32'd100, 32'd7);
    tick();
    idle_in();
    tick();
    flush = 1'b1;
    rd_en = 1'b1;
    rd_ura = 7'b0100001;
    #1;
    check("other_grp_stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    rd_en = 1'b0;
    wait_busy(n);
    pop_check("div_flush_commit");
    check("div_flush_lo", lo, 32'd14);

    // mult then mtlo while busy
    sb_q.push_back(model(MD_MTLO, 32'h0000_CAFE, 32'd0,
                         model(MD_MULT, 32'h0001_0000, 32'h0003_0000, m_hl)));
    present(MD_MULT, 32'h0001_0000, 32'h0003_0000);
    tick();
    present(MD_MTLO, 32'h0000_CAFE, 32'd0);
    wait_stall(n);
    check("mtlo_stall_cycles", n, 5);
    tick();
    idle_in();
    @(negedge clk);
    check("b2b_hi", hi, 32'd3);
    check("b2b_lo", lo, 32'h0000_CAFE);
    pop_check("b2b");

    // -2^31 / -1
    run_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // unknown op code behaves as a nop
    present(4'd13, 32'd9, 32'd9);
    tick();
    idle_in();
    @(negedge clk);
    check("unk_busy", busy, 1'b0);
    check("unk_hilo", {hi, lo}, m_hl);

    // randomised arithmetic against the model
    for (int i = 0; i < 8; i++) begin
      ro = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
      if (i % 3 == 0) rb = -rb;
      run_op("rand", ro, ra, rb, (ro >= MD_DIV) ? 10 : 5);
    end

`ifdef MD_MADD_EN
    run_op("madd_mthi", MD_MTHI, 32'd0, 32'd0, 0);
    run_op("madd_mtlo", MD_MTLO, 32'd5, 32'd0, 0);
    run_op("madd", MD_MADD, 32'd2, 32'd3, 5);
    check("madd_lo", lo, 32'd11);
    check("madd_hi", hi, 32'd0);
    run_op("msub", MD_MSUB, 32'd4, 32'd5, 5);
    check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF7);
`else
    present(MD_MADD, 32'd2, 32'd3);
    tick();
    idle_in();
    @(negedge clk);
    check("madd_off_busy", busy, 1'b0);
    check("madd_off_hilo", {hi, lo}, m_hl);
`endif

    // reset in the middle of a div
    run_op("pre_rst_mtlo", MD_MTLO, 32'h0000_BEEF, 32'd0, 0);
    present(MD_DIV, 32'd100, 32'd3);
    tick();
    idle_in();
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", busy, 1'b0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("postrst_busy", busy, 1'b0);
    check("postrst_hilo", {hi, lo}, 64'd0);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
